// File: rtl/tank_level_if.sv
// Valve-command / level-sensor bundle between the irrigation controller (master)
// and the tank plant (slave).
interface tank_level_if;
   logic inlet_valve;
   logic sprinkler_valve;
   logic drip_valve;
   logic high;
   logic middle;
   logic low;

   modport master (
      output inlet_valve,
      output sprinkler_valve,
      output drip_valve,
      input  high,
      input  middle,
      input  low
   );

   modport slave (
      input  inlet_valve,
      input  sprinkler_valve,
      input  drip_valve,
      output high,
      output middle,
      output low
   );
endinterface

// File: rtl/tank_level_model.sv
// Water-tank plant: integrates valve flows into a saturating level once per tick
// and reports high/middle/low sensor bits derived from the stored level.
module tank_level_model #(
   parameter int unsigned LEVEL_W        = 8,
   parameter int unsigned MAX_LEVEL      = 200,
   parameter int unsigned INIT_LEVEL     = 0,
   parameter int unsigned LOW_TH         = 20,
   parameter int unsigned MID_TH         = 100,
   parameter int unsigned HIGH_TH        = 180,
   parameter int unsigned INLET_RATE     = 4,
   parameter int unsigned SPRINKLER_RATE = 3,
   parameter int unsigned DRIP_RATE      = 1,
   parameter int unsigned TICK_DIV       = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               step,
   input  logic               fault_inject,
   tank_level_if.slave        tank,
   output logic [LEVEL_W-1:0] level,
   output logic               overflow,
   output logic               dry
);

   localparam int unsigned CntW  = $clog2(TICK_DIV);
   localparam int unsigned CalcW = LEVEL_W + 2;

   localparam logic [CntW-1:0]           CntLast  = CntW'(TICK_DIV - 1);
   localparam logic signed [CalcW-1:0]   InletS   = CalcW'(INLET_RATE);
   localparam logic signed [CalcW-1:0]   SprinkS  = CalcW'(SPRINKLER_RATE);
   localparam logic signed [CalcW-1:0]   DripS    = CalcW'(DRIP_RATE);
   localparam logic signed [CalcW-1:0]   MaxS     = CalcW'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0]        MaxLevel = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0]        InitLvl  = LEVEL_W'(INIT_LEVEL);
   localparam logic [LEVEL_W-1:0]        LowTh    = LEVEL_W'(LOW_TH);
   localparam logic [LEVEL_W-1:0]        MidTh    = LEVEL_W'(MID_TH);
   localparam logic [LEVEL_W-1:0]        HighTh   = LEVEL_W'(HIGH_TH);

   typedef enum logic [1:0] {StDry, StLow, StMid, StHigh} region_e;

   localparam region_e RegionInit = (INIT_LEVEL >= HIGH_TH) ? StHigh :
                                    (INIT_LEVEL >= MID_TH)  ? StMid  :
                                    (INIT_LEVEL >= LOW_TH)  ? StLow  : StDry;

   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [LEVEL_W-1:0]      level_q, level_d;
   logic                    overflow_q, overflow_d;
   logic                    dry_q, dry_d;
   logic                    fault_q, fault_d;
   region_e                 region_q, region_d;

   logic                    wrap;
   logic                    tick;
   logic signed [CalcW-1:0] lvl_ext, inc, dec_s, dec_d, nxt;
   logic [2:0]              sens;

   // Prescaler: frozen (not cleared) while run is low.
   always_comb begin
      wrap  = run && (cnt_q == CntLast);
      tick  = wrap | step;
      cnt_d = cnt_q;
      if (run) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
   end

   // Level integration with saturation; valves only matter in the tick cycle.
   always_comb begin
      lvl_ext    = signed'({2'b00, level_q});
      inc        = tank.inlet_valve     ? InletS  : '0;
      dec_s      = tank.sprinkler_valve ? SprinkS : '0;
      dec_d      = tank.drip_valve      ? DripS   : '0;
      nxt        = lvl_ext + inc - dec_s - dec_d;
      level_d    = level_q;
      overflow_d = 1'b0;
      dry_d      = 1'b0;
      if (tick) begin
         if (nxt > MaxS) begin
            level_d    = MaxLevel;
            overflow_d = 1'b1;
         end else if (nxt[CalcW-1]) begin
            level_d = '0;
            dry_d   = 1'b1;
         end else begin
            level_d = nxt[LEVEL_W-1:0];
         end
      end
   end

   // Sensor-region FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         region_q <= RegionInit;
      end else begin
         region_q <= region_d;
      end
   end

   // Sensor-region FSM: next state follows the stored level, skipping regions if needed
   always_comb begin
      region_d = StDry;
      if (level_q >= HighTh) begin
         region_d = StHigh;
      end else if (level_q >= MidTh) begin
         region_d = StMid;
      end else if (level_q >= LowTh) begin
         region_d = StLow;
      end
   end

   // Sensor-region FSM: outputs, with the registered fault overriding high/middle
   always_comb begin
      sens = 3'b000;
      unique case (region_q)
         StDry:   sens = 3'b000;
         StLow:   sens = 3'b001;
         StMid:   sens = 3'b011;
         StHigh:  sens = 3'b111;
         default: sens = 3'b000;
      endcase
      tank.high   = sens[2] | fault_q;
      tank.middle = sens[1] & ~fault_q;
      tank.low    = sens[0];
   end

   assign fault_d = fault_inject;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         level_q    <= InitLvl;
         overflow_q <= 1'b0;
         dry_q      <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         dry_q      <= dry_d;
         fault_q    <= fault_d;
      end
   end

   assign level    = level_q;
   assign overflow = overflow_q;
   assign dry      = dry_q;

endmodule

// File: tb/tb_tank_level_model.sv
// Directed bench for tank_level_model with TICK_DIV=4; expected values are
// computed from the documented fill/drain rates and sensor thresholds.
module tb_tank_level_model;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       fault_inject = 1'b0;
   logic [7:0] level;
   logic       overflow;
   logic       dry;

   int n_vec = 0;
   int n_err = 0;

   tank_level_if tank_if ();

   tank_level_model #(
      .TICK_DIV (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .step         (step),
      .fault_inject (fault_inject),
      .tank         (tank_if),
      .level        (level),
      .overflow     (overflow),
      .dry          (dry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] sens_of(input int l);
      return {l >= 180, l >= 100, l >= 20};
   endfunction

   function automatic logic [2:0] sensors();
      return {tank_if.high, tank_if.middle, tank_if.low};
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_step();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
   endtask

   task automatic set_valves(input logic i, input logic s, input logic d);
      tank_if.inlet_valve     = i;
      tank_if.sprinkler_valve = s;
      tank_if.drip_valve      = d;
   endtask

   initial begin
      int e, p, raw;
      set_valves(1'b0, 1'b0, 1'b0);

      // Reset state
      @(negedge clk);
      check("rst_level", level, 0);
      check("rst_sensors", sensors(), 3'b000);
      check("rst_ovf", overflow, 0);
      check("rst_dry", dry, 0);

      // Fill: +4 per tick, saturating at 200; sensors lag one tick in this sampling
      rst_n = 1'b1;
      run   = 1'b1;
      set_valves(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 60; k++) begin
         wait_cycles(4);
         raw = 4 * k;
         e   = (raw > 200) ? 200 : raw;
         p   = (4 * (k - 1) > 200) ? 200 : 4 * (k - 1);
         check($sformatf("fill%0d_level", k), level, e);
         check($sformatf("fill%0d_ovf", k), overflow, (raw > 200) ? 1 : 0);
         check($sformatf("fill%0d_dry", k), dry, 0);
         check($sformatf("fill%0d_sens", k), sensors(), sens_of(p));
      end
      wait_cycles(1);
      check("ovf_single_cycle", overflow, 0);
      check("full_sensors", sensors(), 3'b111);

      // Drain: -4 per tick from 200, clipping at 0; a mid-interval valve glitch must be ignored
      set_valves(1'b0, 1'b1, 1'b1);
      for (int k = 1; k <= 55; k++) begin
         if (k == 1) begin
            wait_cycles(3);
         end else if (k == 2) begin
            wait_cycles(1);
            set_valves(1'b1, 1'b0, 1'b0);
            wait_cycles(2);
            set_valves(1'b0, 1'b1, 1'b1);
            wait_cycles(1);
         end else begin
            wait_cycles(4);
         end
         raw = 200 - 4 * k;
         e   = (raw < 0) ? 0 : raw;
         p   = (200 - 4 * (k - 1) < 0) ? 0 : 200 - 4 * (k - 1);
         check($sformatf("drain%0d_level", k), level, e);
         check($sformatf("drain%0d_dry", k), dry, (raw < 0) ? 1 : 0);
         check($sformatf("drain%0d_ovf", k), overflow, 0);
         check($sformatf("drain%0d_sens", k), sensors(), sens_of(p));
      end

      // Frozen prescaler, single steps
      run = 1'b0;
      set_valves(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         do_step();
         check($sformatf("step_in%0d", k), level, 4 * k);
      end
      set_valves(1'b0, 1'b0, 1'b1);
      do_step();
      check("step_drip1", level, 11);
      do_step();
      check("step_drip2", level, 10);
      wait_cycles(20);
      check("frozen_level", level, 10);
      check("frozen_sens", sensors(), 3'b000);
      set_valves(1'b1, 1'b1, 1'b0);
      do_step();
      check("net_plus1_a", level, 11);
      do_step();
      check("net_plus1_b", level, 12);
      set_valves(1'b1, 1'b1, 1'b1);
      do_step();
      check("all_open_level", level, 12);
      check("all_open_ovf", overflow, 0);
      check("all_open_dry", dry, 0);

      // Step coinciding with the prescaler wrap is one tick
      set_valves(1'b1, 1'b0, 1'b0);
      run = 1'b1;
      wait_cycles(3);
      check("prewrap_level", level, 12);
      step = 1'b1;
      wait_cycles(1);
      step = 1'b0;
      run  = 1'b0;
      check("wrap_step_level", level, 16);
      wait_cycles(4);
      check("wrap_step_hold", level, 16);

      // Fault injection at level 120
      repeat (26) do_step();
      wait_cycles(1);
      check("lvl120", level, 120);
      check("lvl120_sens", sensors(), 3'b011);
      fault_inject = 1'b1;
      wait_cycles(1);
      check("fault_sens", sensors(), 3'b101);
      check("fault_level", level, 120);
      fault_inject = 1'b0;
      wait_cycles(1);
      check("unfault_sens", sensors(), 3'b011);

      // Asynchronous reset in the middle of a prescaler interval at level 150
      repeat (8) do_step();
      set_valves(1'b0, 1'b0, 1'b1);
      repeat (2) do_step();
      check("lvl150", level, 150);
      set_valves(1'b0, 1'b0, 1'b0);
      run = 1'b1;
      wait_cycles(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_level", level, 0);
      check("async_rst_sens", sensors(), 3'b000);
      check("async_rst_ovf", overflow, 0);
      check("async_rst_dry", dry, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b0;
      wait_cycles(2);
      check("post_rst_level", level, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
